// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, LSB first, mid-bit sampling.
// Ports: clk, reset (async, active-low), rx (async serial in, idle high),
//        rx_data (last good byte), rx_done_tick (write strobe),
//        frame_err (low stop bit pulse), busy (not idle).
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16,
    parameter int BAUD_DIV  = 326
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]    SB_LAST   = 4'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_nxt;

    logic                 rx_meta;
    logic                 rx_sync;
    logic [15:0]          baud_cnt;
    logic                 tick;
    logic [3:0]           s_cnt, s_nxt;
    logic [NW-1:0]        n_cnt, n_nxt;
    logic [DATA_BITS-1:0] shreg, sh_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 done_nxt;
    logic                 err_nxt;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running baud divider; never realigned to the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    assign tick = (baud_cnt == BAUD_LAST);

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            s_cnt        <= s_nxt;
            n_cnt        <= n_nxt;
            shreg        <= sh_nxt;
            rx_data      <= data_nxt;
            rx_done_tick <= done_nxt;
            frame_err    <= err_nxt;
        end
    end

    // Next-state and datapath updates; all moves except leaving IDLE
    // happen only on a tick.
    always_comb begin
        state_nxt = state;
        s_nxt     = s_cnt;
        n_nxt     = n_cnt;
        sh_nxt    = shreg;
        data_nxt  = rx_data;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_nxt = START;
                    s_nxt     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == 4'd7) begin
                        if (!rx_sync) begin
                            state_nxt = DATA;
                            s_nxt     = '0;
                            n_nxt     = '0;
                        end else begin
                            // Start bit gone by mid-bit: a glitch.
                            state_nxt = IDLE;
                        end
                    end else begin
                        s_nxt = s_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        s_nxt  = '0;
                        sh_nxt = {rx_sync, shreg[DATA_BITS-1:1]};
                        if (n_cnt == N_LAST) begin
                            state_nxt = STOP;
                        end else begin
                            n_nxt = n_cnt + NW'(1);
                        end
                    end else begin
                        s_nxt = s_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt == SB_LAST) begin
                        state_nxt = IDLE;
                        if (rx_sync) begin
                            data_nxt = shreg;
                            done_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        s_nxt = s_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore output.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an expected-event queue model.
// Checks every clk: pulse kind/order, rx_data, idle busy.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .DATA_BITS(8),
        .SB_TICKS (16),
        .BAUD_DIV (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_done_tick(rx_done_tick),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data;
    int         total;
    int         bad;
    int         done_cnt;
    int         err_cnt;
    bit         chk_en;
    bit         idle_expect;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, expv, $time);
        end
    endtask

    task automatic push(input bit is_err, input logic [7:0] d);
        ev_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    // One 8N1 frame, 64 clk per bit; a bad stop bit is held low past
    // its middle and then released.
    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        rx = 1'b0;
        repeat (64) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (64) @(posedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (64) @(posedge clk);
        end else begin
            rx = 1'b0;
            repeat (44) @(posedge clk);
            rx = 1'b1;
            repeat (20) @(posedge clk);
        end
    endtask

    task automatic wait_empty(input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (reset && chk_en) begin
            if (rx_done_tick || frame_err) begin
                if (rx_done_tick) done_cnt++;
                if (frame_err) err_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious", {30'b0, rx_done_tick, frame_err}, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("kind_err", frame_err, e.is_err);
                    chk("kind_done", rx_done_tick, !e.is_err);
                    if (!e.is_err) model_data = e.data;
                end
            end
            chk("rx_data", rx_data, model_data);
            if (idle_expect) begin
                chk("idle_busy", busy, 0);
            end
        end
    end

    initial begin
        int d0;
        int e0;
        total       = 0;
        bad         = 0;
        done_cnt    = 0;
        err_cnt     = 0;
        chk_en      = 1'b0;
        idle_expect = 1'b0;
        model_data  = 8'h00;
        reset       = 1'b0;
        rx          = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", rx_data, 0);
        chk("rst_done", rx_done_tick, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Idle line for 5000 clk.
        idle_expect = 1'b1;
        repeat (5000) @(posedge clk);
        idle_expect = 1'b0;

        // Single good frame.
        push(0, 8'h55);
        send_byte(8'h55, 1);
        wait_empty(200);
        @(negedge clk);
        chk("busy_after_55", busy, 0);
        chk("lit_55", rx_data, 8'h55);

        // Back-to-back frames.
        d0 = done_cnt;
        push(0, 8'hA3);
        push(0, 8'h0F);
        send_byte(8'hA3, 1);
        chk("lit_A3", rx_data, 8'hA3);
        send_byte(8'h0F, 1);
        wait_empty(200);
        chk("b2b_count", done_cnt - d0, 2);
        chk("lit_0F", rx_data, 8'h0F);

        // Start glitch of 24 clk.
        repeat (50) @(posedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        repeat (14) @(posedge clk);
        rx = 1'b1;
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        repeat (100) @(posedge clk);
        chk("glitch_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // Good frame, then one with a low stop bit.
        push(0, 8'h12);
        send_byte(8'h12, 1);
        wait_empty(200);
        d0 = done_cnt;
        e0 = err_cnt;
        push(1, 8'h00);
        send_byte(8'hFF, 0);
        wait_empty(200);
        repeat (200) @(posedge clk);
        chk("ferr_count", err_cnt - e0, 1);
        chk("ferr_no_done", done_cnt - d0, 0);
        chk("lit_12_kept", rx_data, 8'h12);
        chk("ferr_idle", busy, 0);

        // Reset in the middle of the data bits of 0x3C.
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (64) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h3C >> i) & 8'h01) != 0;
            repeat (64) @(posedge clk);
        end
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        model_data = 8'h00;
        reset = 1'b0;
        rx = 1'b1;
        #1;
        chk("mid_rst_data", rx_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", rx_done_tick, 0);
        chk("mid_rst_err", frame_err, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (700) @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        push(0, 8'hC3);
        send_byte(8'hC3, 1);
        wait_empty(200);
        chk("lit_C3", rx_data, 8'hC3);

        // Break: one error per frame time; release lands in the
        // fourth frame's data bits, which then read as all ones.
        repeat (50) @(posedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        push(1, 8'h00);
        push(1, 8'h00);
        push(1, 8'h00);
        push(0, 8'hFF);
        rx = 1'b0;
        repeat (1900) @(posedge clk);
        rx = 1'b1;
        wait_empty(1000);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("break_errs", err_cnt - e0, 3);
        chk("break_done", done_cnt - d0, 1);
        chk("lit_FF", rx_data, 8'hFF);
        chk("break_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, the number of data bits per frame, sent LSB first.
REQ-002 SHALL have parameter SB_TICKS, default 16, the number of oversample ticks in the stop bit (16 = 1 stop bit).
REQ-003 SHALL have parameter BAUD_DIV, default 326, the clk cycles per oversample tick (16x baud), legal range 2..65535.
REQ-004 clk  input  1  system clock; all logic SHALL be clocked on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 rx_data  output  DATA_BITS  last correctly framed byte, registered.
REQ-008 rx_done_tick  output  1  one-clk pulse when rx_data is updated; it is the FIFO write strobe.
REQ-009 frame_err  output  1  one-clk pulse when a frame ends with a low stop bit.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_sync) before any use; the synchronizer flops SHALL reset to 1.
REQ-012 Baud generator: a free-running 16-bit counter SHALL count 0..BAUD_DIV-1 and wrap to 0; tick SHALL be high for exactly one clk when the count equals BAUD_DIV-1.
REQ-013 The baud counter SHALL NOT be resynchronized on a start edge; up to 1 tick of phase error is accepted.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP. Counters: s_cnt (4 bits, tick counter) and n_cnt (bit index, log2(DATA_BITS) bits, minimum 1 bit).
REQ-015 IDLE: when rx_sync=0, the FSM SHALL go to START and clear s_cnt; otherwise it SHALL hold.
REQ-016 START, on tick with s_cnt=7: if rx_sync=0, the FSM SHALL go to DATA and clear s_cnt and n_cnt; if rx_sync=1, it SHALL treat the start as a glitch, return to IDLE, and assert no outputs.
REQ-017 START, on tick with s_cnt<7: s_cnt SHALL increment.
REQ-018 DATA, on tick with s_cnt=15: s_cnt SHALL clear and the shift register SHALL load {rx_sync, shreg[DATA_BITS-1:1]}.
REQ-019 On that same DATA tick, the FSM SHALL go to STOP if n_cnt=DATA_BITS-1; otherwise n_cnt SHALL increment.
REQ-020 DATA, on tick with s_cnt<15: s_cnt SHALL increment.
REQ-021 STOP, on tick with s_cnt=SB_TICKS-1 and rx_sync=1: the FSM SHALL go to IDLE, load rx_data from the shift register, and pulse rx_done_tick.
REQ-022 STOP, on tick with s_cnt=SB_TICKS-1 and rx_sync=0: the FSM SHALL go to IDLE and pulse frame_err; rx_data SHALL hold and rx_done_tick SHALL stay low.
REQ-023 STOP, on tick with s_cnt<SB_TICKS-1: s_cnt SHALL increment.
REQ-024 All sampling points SHALL be mid-bit: the start bit at tick 8, then every 16 ticks after it.
REQ-025 rx_done_tick and frame_err SHALL be registered, asserted in the clk after the completing tick, and never high together.
REQ-026 On return to IDLE, a low rx_sync in the next clk SHALL start a new frame; back-to-back frames SHALL be received with no lost bits.
REQ-027 A continuous low on rx (break) SHALL produce one frame_err per frame time and no rx_done_tick.
REQ-028 Between ticks, state and counters SHALL hold; only the synchronizer and the baud counter advance every clk.

Reset
REQ-029 reset=0 SHALL immediately force: state IDLE, s_cnt=0, n_cnt=0, shreg=0, baud counter=0, rx_data=0, rx_done_tick=0, frame_err=0, busy=0, synchronizer=1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release the block SHALL wait in IDLE for a falling edge on rx.

Verification (BAUD_DIV=4, so 1 bit = 64 clk)
REQ-031 Frame 0x55, 8N1 -> one rx_done_tick, rx_data=0x55, frame_err never high, busy low after the stop bit.
REQ-032 Frames 0xA3 then 0x0F, back-to-back with no idle gap -> two rx_done_tick pulses, rx_data=0xA3 then 0x0F.
REQ-033 rx low for 24 clk, then high -> no output pulses, busy returns to 0 within 40 clk of the falling edge.
REQ-034 Frame 0xFF with stop bit driven 0, after a good frame 0x12 -> one frame_err pulse, no rx_done_tick, rx_data stays 0x12.
REQ-035 reset pulsed low mid-DATA of frame 0x3C -> all outputs 0 immediately and no pulse; a following frame 0xC3 -> rx_done_tick with rx_data=0xC3.
REQ-036 rx held high for 5000 clk after reset -> busy, rx_done_tick and frame_err stay 0 throughout.
